// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional macro BCD_BLANK_EN adds a registered leading-zero blank mask.
module bcd_seq_converter #(
  parameter int W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
`ifdef BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);
  localparam int N = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [N-1:0] dig, adj, res;
  logic [W-1:0] sh;
  logic [CW-1:0] cnt;
  logic sticky, ovf_n;
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign adj[4*d+:4] = dig[4*d+:4] > 4'd4 ? dig[4*d+:4] + 4'd3 : dig[4*d+:4];
  end
  // a carry out of the top digit means the operand exceeds DIGITS decimal places
  assign ovf_n = sticky | adj[N-1];
  assign res = ovf_n ? {DIGITS{4'h9}} : {adj[N-2:0], sh[W-1]};
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] bl;
  logic z;
  always_comb begin
    bl = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      z = z & (res[4*i+:4] == 4'd0);
      bl[i] = z;
    end
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy <= 1'b0;
      valid <= 1'b0;
      bcd <= '0;
      overflow <= 1'b0;
      dig <= '0;
      sh <= '0;
      cnt <= '0;
      sticky <= 1'b0;
`ifdef BCD_BLANK_EN
      blank <= ~DIGITS'(1);
`endif
    end else if (state != SHIFT) begin
      if (start) begin
        state <= SHIFT;
        ready <= 1'b0;
        busy <= 1'b1;
        valid <= 1'b0;
        dig <= '0;
        sh <= bin;
        cnt <= CW'(W);
        sticky <= 1'b0;
      end
    end else begin
      dig <= {adj[N-2:0], sh[W-1]};
      sh <= {sh[W-2:0], 1'b0};
      sticky <= ovf_n;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state <= DONE;
        ready <= 1'b1;
        busy <= 1'b0;
        valid <= 1'b1;
        bcd <= res;
        overflow <= ovf_n;
`ifdef BCD_BLANK_EN
        blank <= bl;
`endif
      end
    end
  end
endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb_bcd_seq_converter: directed plus random checks of two converter instances (3 and 2 digits).
module tb_bcd_seq_converter;
  logic clk = 0, rst = 1;
  logic start_a = 0, start_b = 0;
  logic [7:0] bin_a = 0, bin_b = 0;
  logic ready_a, busy_a, valid_a, ovf_a, ready_b, busy_b, valid_b, ovf_b;
  logic [11:0] bcd_a;
  logic [7:0] bcd_b;
  int total = 0, passed = 0;
`ifdef BCD_BLANK_EN
  logic [2:0] blank_a;
  logic [1:0] blank_b;
`endif
  bcd_seq_converter #(.W(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bin(bin_a), .ready(ready_a), .busy(busy_a),
    .valid(valid_a), .bcd(bcd_a), .overflow(ovf_a)
`ifdef BCD_BLANK_EN
    , .blank(blank_a)
`endif
  );
  bcd_seq_converter #(.W(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bin(bin_b), .ready(ready_b), .busy(busy_b),
    .valid(valid_b), .bcd(bcd_b), .overflow(ovf_b)
`ifdef BCD_BLANK_EN
    , .blank(blank_b)
`endif
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] model(input int v, input int nd, output logic ov);
    int lim = (nd == 3) ? 1000 : 100;
    ov = v >= lim;
    if (ov) return (nd == 3) ? 12'h999 : 12'h099;
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic convert(input bit sel, input int v);
    int n = 0, bc = 0;
    logic ov;
    logic [11:0] exp = model(v, sel ? 2 : 3, ov);
    @(posedge clk); #1;
    if (sel) begin start_b = 1; bin_b = 8'(v); end
    else begin start_a = 1; bin_a = 8'(v); end
    @(posedge clk); #1;
    start_a = 0; start_b = 0;
    bin_a = 8'($urandom); bin_b = 8'($urandom);
    while (!(sel ? valid_b : valid_a) && n < 40) begin
      bc += int'(sel ? busy_b : busy_a);
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("latency v=%0d", v), n, 8);
    check($sformatf("busy_cycles v=%0d", v), bc, 8);
    check($sformatf("bcd v=%0d d=%0d", v, sel ? 2 : 3), sel ? {4'h0, bcd_b} : bcd_a, exp);
    check($sformatf("overflow v=%0d", v), sel ? ovf_b : ovf_a, ov);
`ifdef BCD_BLANK_EN
    if (!sel) check($sformatf("blank v=%0d", v), blank_a,
                    {exp[11:8] == 0, exp[11:4] == 0, 1'b0});
`endif
  endtask

  initial begin
    logic ov;
    int n;
    #12;
    check("reset_ready", ready_a, 1);
    check("reset_busy", busy_a, 0);
    check("reset_valid", valid_a, 0);
    check("reset_bcd", bcd_a, 0);
    check("reset_ovf", ovf_a, 0);
`ifdef BCD_BLANK_EN
    check("reset_blank", blank_a, 3'b110);
`endif
    rst = 0;
    convert(0, 255);
    convert(0, 0);
    convert(0, 9);
    convert(0, 7);
    convert(0, 40);
    convert(0, 205);
    convert(1, 100);
    convert(1, 99);
    convert(1, 255);
    convert(1, 0);
    // start pulsed during SHIFT must be ignored
    @(posedge clk); #1;
    start_a = 1; bin_a = 8'd42;
    @(posedge clk); #1;
    start_a = 0;
    repeat (2) @(posedge clk);
    #1 start_a = 1; bin_a = 8'd7;
    @(posedge clk); #1;
    start_a = 0;
    n = 0;
    while (!valid_a && n < 40) begin @(posedge clk); #1; n++; end
    check("ignored_start_bcd", bcd_a, 12'h042);
    // held start in DONE restarts at once with valid low for W cycles
    start_a = 1; bin_a = 8'd42;
    @(posedge clk); #1;
    check("restart_valid_fall", valid_a, 0);
    n = 1;
    while (!valid_a && n < 40) begin @(posedge clk); #1; n++; end
    start_a = 0;
    check("restart_valid_low_cycles", n, 9);
    check("restart_bcd", bcd_a, 12'h042);
    // asynchronous reset mid-conversion
    @(posedge clk); #1;
    start_a = 1; bin_a = 8'd200;
    @(posedge clk); #1;
    start_a = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    #1;
    check("abort_ready", ready_a, 1);
    check("abort_busy", busy_a, 0);
    check("abort_valid", valid_a, 0);
    check("abort_bcd", bcd_a, 0);
    @(negedge clk) rst = 0;
    convert(0, 128);
    for (int i = 0; i < 20; i++) convert(0, int'($urandom_range(0, 255)));
    for (int i = 0; i < 10; i++) convert(1, int'($urandom_range(0, 255)));
    check("model_sanity_99", model(99, 2, ov), 12'h099);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
